axi4_lite_req_arbiter: RTL

- Round-robin scheduler that shares the single AXI4-Lite master between NUM_REQ requesters (e.g. MAC config writer, status poller, debug port).
- Accepts one read or write command at a time and drives the master's START_READ/START_WRITE/address/W_data.
- Snoops the master's AXI response handshakes to detect completion, then returns read data and response code to the requester that issued the command.

---
 rtl/axi4_lite_req_arbiter_pkg.sv | 15 +
 rtl/axi4_lite_req_arbiter_if.sv | 47 ++++
 rtl/axi4_lite_req_arbiter_rr_arbiter.sv | 31 +++
 rtl/axi4_lite_req_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared types and response codes for the AXI4-Lite requester arbiter.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_HALT
    } arb_state_t;

endpackage

// File: rtl/axi4_lite_req_arbiter_if.sv
// Requester-side command/response bus plus the AXI4-Lite master control and snoop signals.
interface axi4_lite_req_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDRESS-1:0]    req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [1:0]                    rsp_resp;
    logic                          busy;
    logic                          hung;

    logic                          START_READ;
    logic                          START_WRITE;
    logic [ADDRESS-1:0]            address;
    logic [DATA_WIDTH-1:0]         W_data;
    logic                          M_RVALID;
    logic                          M_RREADY;
    logic                          M_BVALID;
    logic                          M_BREADY;
    logic [DATA_WIDTH-1:0]         M_RDATA;
    logic [1:0]                    M_RRESP;
    logic [1:0]                    M_BRESP;

    // Arbiter view.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  M_RVALID, M_RREADY, M_BVALID, M_BREADY, M_RDATA, M_RRESP, M_BRESP,
        output req_ready, rsp_valid, rsp_data, rsp_resp, busy, hung,
        output START_READ, START_WRITE, address, W_data
    );

    // Requesters plus the AXI master/bus seen from outside the arbiter.
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output M_RVALID, M_RREADY, M_BVALID, M_BREADY, M_RDATA, M_RRESP, M_BRESP,
        input  req_ready, rsp_valid, rsp_data, rsp_resp, busy, hung,
        input  START_READ, START_WRITE, address, W_data
    );

endinterface

// File: rtl/axi4_lite_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', wrapping around.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    grant_idx,
    output logic               grant_any
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(last) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_any && req[IDXW'(idx)]) begin
                grant_any          = 1'b1;
                grant_idx          = IDXW'(idx);
                grant[IDXW'(idx)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one AXI4-Lite master among NUM_REQ requesters; one command in flight at a time,
// completion detected by snooping the R/B handshakes, with a hang timeout.
module axi4_lite_req_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDRESS        = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axi4_lite_req_arbiter_if.slave   bus
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);
    localparam int unsigned CNTW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t             state_q, state_d;
    logic [IDXW-1:0]        last_q, cap_idx_q, grant_idx;
    logic [NUM_REQ-1:0]     grant_oh;
    logic                   grant_any;
    logic                   cap_write_q;
    logic [ADDRESS-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
    logic [1:0]             resp_q;
    logic                   hung_q;
    logic                   start_rd_q, start_wr_q;
    logic [CNTW-1:0]        tcnt_q;
    logic                   cmp_hs, tmo;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (bus.req_valid),
        .last      (last_q),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        state_d = state_q;
        cmp_hs  = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE:  if (grant_any) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // Only the channel matching the issued command counts; it beats a same-cycle timeout.
                cmp_hs = cap_write_q ? (bus.M_BVALID && bus.M_BREADY)
                                     : (bus.M_RVALID && bus.M_RREADY);
                if (cmp_hs) begin
                    state_d = ST_RESP;
                end else if (tcnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    tmo     = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = hung_q ? ST_HALT : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            last_q      <= IDXW'(NUM_REQ - 1);
            cap_idx_q   <= '0;
            cap_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            hung_q      <= 1'b0;
            start_rd_q  <= 1'b0;
            start_wr_q  <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            start_rd_q <= 1'b0;
            start_wr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        last_q      <= grant_idx;
                        cap_idx_q   <= grant_idx;
                        cap_write_q <= bus.req_write[grant_idx];
                        addr_q      <= bus.req_addr[grant_idx*ADDRESS +: ADDRESS];
                        wdata_q     <= bus.req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                        start_wr_q  <= bus.req_write[grant_idx];
                        start_rd_q  <= !bus.req_write[grant_idx];
                    end
                end
                ST_ISSUE: tcnt_q <= '0;
                ST_WAIT: begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (cmp_hs) begin
                        rdata_q <= cap_write_q ? '0 : bus.M_RDATA;
                        resp_q  <= cap_write_q ? bus.M_BRESP : bus.M_RRESP;
                    end else if (tmo) begin
                        rdata_q <= '0;
                        resp_q  <= RESP_SLVERR;
                        hung_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE) ? grant_oh : '0;
    assign bus.rsp_valid   = (state_q == ST_RESP) ? (NUM_REQ'(1) << cap_idx_q) : '0;
    assign bus.rsp_data    = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.rsp_resp    = (state_q == ST_RESP) ? resp_q : RESP_OKAY;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.hung        = hung_q;
    assign bus.START_READ  = start_rd_q;
    assign bus.START_WRITE = start_wr_q;
    assign bus.address     = addr_q;
    assign bus.W_data      = wdata_q;

endmodule
